// File: rtl/sram32k_arbiter.sv
// rtl/sram32k_arbiter.sv - two-port round-robin arbiter and cycle sequencer for a 32K x 8 async SRAM
//
// Ports:
//   CLK, RST                     clock, synchronous active-high reset
//   REQx, WRx, ADDRx, WDATAx     port x request (held stable until GNTx)
//   GNTx                         port x accepted this cycle (combinational)
//   DONEx                        one-cycle pulse, port x transaction complete
//   RDATA                        last read data, valid from the DONE cycle of a read
//   MEM_A, MEM_IO                SRAM address and bidirectional data bus
//   MEM_CS, MEM_OE, MEM_WE       SRAM active-low controls, all registered
module sram32k_arbiter #(
    parameter int ADDR_W        = 15,
    parameter int DATA_W        = 8,
    parameter int STROBE_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ0,
    input  logic              WR0,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [DATA_W-1:0] WDATA0,
    output logic              GNT0,
    output logic              DONE0,
    input  logic              REQ1,
    input  logic              WR1,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [DATA_W-1:0] WDATA1,
    output logic              GNT1,
    output logic              DONE1,
    output logic [DATA_W-1:0] RDATA,
    output logic [ADDR_W-1:0] MEM_A,
    inout  wire  [DATA_W-1:0] MEM_IO,
    output logic              MEM_CS,
    output logic              MEM_OE,
    output logic              MEM_WE
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    localparam int              CNT_W    = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STROBE_CYCLES - 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              wr_q;
    logic              port_q;
    logic              last_port;   // 1: port 1 was served most recently
    logic              drive;
    logic [DATA_W-1:0] wdata_q;
    logic              idle;

    assign idle = (state == ST_IDLE);

    // On contention the port not served last wins; the two terms are exclusive.
    assign GNT0 = idle & REQ0 & (~REQ1 | last_port);
    assign GNT1 = idle & REQ1 & (~REQ0 | ~last_port);

    // The bus is only driven for writes, from SETUP through HOLD, so it can
    // never collide with the SRAM driving during an OE strobe.
    assign MEM_IO = drive ? wdata_q : {DATA_W{1'bz}};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            wr_q      <= 1'b0;
            port_q    <= 1'b0;
            last_port <= 1'b1;
            drive     <= 1'b0;
            wdata_q   <= '0;
            RDATA     <= '0;
            MEM_A     <= '0;
            MEM_CS    <= 1'b1;
            MEM_OE    <= 1'b1;
            MEM_WE    <= 1'b1;
            DONE0     <= 1'b0;
            DONE1     <= 1'b0;
        end else begin
            DONE0 <= 1'b0;
            DONE1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (GNT0 || GNT1) begin
                        port_q    <= GNT1;
                        last_port <= GNT1;
                        wr_q      <= GNT1 ? WR1 : WR0;
                        drive     <= GNT1 ? WR1 : WR0;
                        MEM_A     <= GNT1 ? ADDR1 : ADDR0;
                        wdata_q   <= GNT1 ? WDATA1 : WDATA0;
                        // Address settles on the same edge CS falls, so it
                        // is stable for the whole CS-low window.
                        MEM_CS    <= 1'b0;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    cnt <= CNT_LOAD;
                    if (wr_q) begin
                        MEM_WE <= 1'b0;
                    end else begin
                        MEM_OE <= 1'b0;
                    end
                    state <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (cnt == '0) begin
                        MEM_OE <= 1'b1;
                        MEM_WE <= 1'b1;
                        if (!wr_q) begin
                            RDATA <= MEM_IO;
                        end
                        DONE0 <= ~port_q;
                        DONE1 <= port_q;
                        state <= ST_HOLD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    MEM_CS <= 1'b1;
                    drive  <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram32k_arbiter.sv
// tb/tb_sram32k_arbiter.sv - scoreboard bench for sram32k_arbiter with behavioural SRAM models
module tb_sram32k_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 0, wr0 = 0, req1 = 0, wr1 = 0;
    logic [14:0] addr0 = '0, addr1 = '0;
    logic [7:0]  wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, done0, done1;
    logic [7:0]  rdata;
    logic [14:0] mem_a;
    wire  [7:0]  mem_io;
    logic        mem_cs, mem_oe, mem_we;

    logic        s_req0 = 0;
    logic [14:0] s_addr0 = '0;
    logic        s_gnt0, s_done0, s_gnt1, s_done1;
    logic [7:0]  s_rdata;
    logic [14:0] s_a;
    wire  [7:0]  s_io;
    logic        s_cs, s_oe, s_we;

    logic [7:0] buffer  [0:32767];
    logic [7:0] ref_mem [0:32767];
    logic [7:0] s_buf   [0:15];

    typedef struct {
        bit         port;
        bit         wr;
        logic [7:0] data;
        int         gcyc;
    } sb_t;
    sb_t sb[$];
    bit  order_q[$];
    int  gcyc_q[$];

    int cyc = 0;
    int check_cnt = 0, pass_cnt = 0;
    int oe_run = 0, we_run = 0, last_oe_len = 0, last_we_len = 0, we_low_total = 0;
    int gnt_overlap = 0, oe_we_both = 0, a_change = 0, wr_bus_err = 0;
    bit cur_wr = 0;
    logic [7:0]  cur_wdata = '0;
    logic [14:0] prev_a = '0;
    logic        prev_cs = 1'b1;

    sram32k_arbiter dut (
        .CLK(clk), .RST(rst),
        .REQ0(req0), .WR0(wr0), .ADDR0(addr0), .WDATA0(wdata0), .GNT0(gnt0), .DONE0(done0),
        .REQ1(req1), .WR1(wr1), .ADDR1(addr1), .WDATA1(wdata1), .GNT1(gnt1), .DONE1(done1),
        .RDATA(rdata), .MEM_A(mem_a), .MEM_IO(mem_io),
        .MEM_CS(mem_cs), .MEM_OE(mem_oe), .MEM_WE(mem_we)
    );

    sram32k_arbiter #(.STROBE_CYCLES(1)) dut_s1 (
        .CLK(clk), .RST(rst),
        .REQ0(s_req0), .WR0(1'b0), .ADDR0(s_addr0), .WDATA0(8'h00), .GNT0(s_gnt0), .DONE0(s_done0),
        .REQ1(1'b0), .WR1(1'b0), .ADDR1(15'h0), .WDATA1(8'h00), .GNT1(s_gnt1), .DONE1(s_done1),
        .RDATA(s_rdata), .MEM_A(s_a), .MEM_IO(s_io),
        .MEM_CS(s_cs), .MEM_OE(s_oe), .MEM_WE(s_we)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Asynchronous SRAM models: drive on CS&OE, capture on CS&WE.
    assign mem_io = (!mem_cs && !mem_oe) ? buffer[mem_a] : 8'hzz;
    assign s_io   = (!s_cs && !s_oe) ? s_buf[s_a[3:0]] : 8'hzz;
    always @(posedge clk) begin
        if (!mem_cs && !mem_we) buffer[mem_a] <= mem_io;
    end

    task automatic check(input string tag, input int act, input int exp);
        check_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Monitor: scoreboard push on grant, pop on DONE, plus bus invariants.
    always @(negedge clk) begin
        if (!mem_oe && !mem_we) oe_we_both++;
        if (!prev_cs && !mem_cs && mem_a != prev_a) a_change++;
        prev_cs = mem_cs;
        prev_a  = mem_a;
        if (!mem_oe) oe_run++;
        else if (oe_run != 0) begin last_oe_len = oe_run; oe_run = 0; end
        if (!mem_we) begin we_run++; we_low_total++; end
        else if (we_run != 0) begin last_we_len = we_run; we_run = 0; end
        if (!mem_cs && cur_wr && mem_io != cur_wdata) wr_bus_err++;
        if (rst) begin
            sb.delete();
            cur_wr = 0;
        end else begin
            if (gnt0 && gnt1) gnt_overlap++;
            if (gnt0 || gnt1) begin
                sb_t it;
                logic [14:0] a;
                it.port = gnt1;
                it.wr   = gnt1 ? wr1 : wr0;
                a       = gnt1 ? addr1 : addr0;
                it.gcyc = cyc;
                if (it.wr) begin
                    it.data = gnt1 ? wdata1 : wdata0;
                    ref_mem[a] = it.data;
                end else begin
                    it.data = ref_mem[a];
                end
                cur_wr    = it.wr;
                cur_wdata = it.data;
                sb.push_back(it);
                order_q.push_back(it.port);
                gcyc_q.push_back(cyc);
            end
            if (done0 || done1) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    check("done_port", int'(done1), int'(e.port));
                    check("done_latency", cyc - e.gcyc, 4);
                    if (!e.wr) check("rdata", rdata, e.data);
                end
            end
        end
    end

    task automatic do_req(input bit p, input bit w, input logic [14:0] a, input logic [7:0] d);
        int n = 0;
        bit got = 0;
        if (!p) begin wr0 = w; addr0 = a; wdata0 = d; req0 = 1; end
        else    begin wr1 = w; addr1 = a; wdata1 = d; req1 = 1; end
        while (!got && n < 50) begin
            @(negedge clk);
            got = p ? gnt1 : gnt0;
            n++;
        end
        check("grant_seen", int'(got), 1);
        @(posedge clk); #1;
        // Scramble the inputs after acceptance; the latched request must win.
        if (!p) begin req0 = 0; addr0 = 15'h7fff; wdata0 = 8'h00; wr0 = ~w; end
        else    begin req1 = 0; addr1 = 15'h7fff; wdata1 = 8'h00; wr1 = ~w; end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
        check("drain", sb.size(), 0);
        @(posedge clk); #1;
        cur_wr = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    initial begin
        int n;
        bit g0, g1;
        for (int i = 0; i < 32768; i++) begin buffer[i] = 8'h00; ref_mem[i] = 8'h00; end
        for (int i = 0; i < 16; i++) s_buf[i] = 8'h00;
        buffer[8] = 8'hFF; ref_mem[8] = 8'hFF;
        buffer[9] = 8'h5A; ref_mem[9] = 8'h5A;
        s_buf[9]  = 8'hAA;

        do_reset();
        @(negedge clk);
        check("rst_cs", mem_cs, 1);
        check("rst_oe", mem_oe, 1);
        check("rst_we", mem_we, 1);
        check("rst_a", mem_a, 0);
        check("rst_rdata", rdata, 0);
        check("rst_done", {done0, done1}, 0);
        @(posedge clk); #1;

        // 1: read of preloaded 0xFF
        we_low_total = 0;
        do_req(0, 0, 15'd8, 8'h00);
        drain();
        check("t1_oe_len", last_oe_len, 2);
        check("t1_we_never_low", we_low_total, 0);
        check("t1_rdata", rdata, 8'hFF);

        // 2: port 1 write then port 0 readback
        do_req(1, 1, 15'd10, 8'hBB);
        drain();
        check("t2_we_len", last_we_len, 2);
        check("t2_buffer", buffer[10], 8'hBB);
        do_req(0, 0, 15'd10, 8'h00);
        drain();
        check("t2_readback", rdata, 8'hBB);

        // 3: both requesting continuously -> alternating grants, 5 cycles apart
        do_reset();
        order_q.delete();
        gcyc_q.delete();
        wr0 = 0; addr0 = 15'd8;  req0 = 1;
        wr1 = 0; addr1 = 15'd10; req1 = 1;
        n = 0;
        while (order_q.size() < 4 && n < 100) begin @(negedge clk); #1; n++; end
        @(posedge clk); #1;
        req0 = 0; req1 = 0;
        check("t3_grants", order_q.size(), 4);
        for (int i = 0; i < 4 && i < order_q.size(); i++) check("t3_order", int'(order_q[i]), i % 2);
        for (int i = 1; i < 4 && i < gcyc_q.size(); i++) check("t3_spacing", gcyc_q[i] - gcyc_q[i-1], 5);
        drain();

        // 4: reset during the write strobe
        do_req(1, 1, 15'd10, 8'h55);
        n = 0;
        while (mem_we && n < 20) begin @(negedge clk); n++; end
        check("t4_in_strobe", mem_we, 0);
        rst = 1;
        @(posedge clk); #1;
        check("t4_cs", mem_cs, 1);
        check("t4_oe", mem_oe, 1);
        check("t4_we", mem_we, 1);
        check("t4_rdata", rdata, 0);
        @(posedge clk); #1 rst = 0;
        repeat (6) @(posedge clk);
        #1;
        order_q.delete();
        wr0 = 0; addr0 = 15'd8; req0 = 1;
        wr1 = 0; addr1 = 15'd9; req1 = 1;
        g0 = 0; g1 = 0; n = 0;
        while (!(g0 && g1) && n < 100) begin
            @(negedge clk);
            if (gnt0) g0 = 1;
            if (gnt1) g1 = 1;
            @(posedge clk); #1;
            if (g0) req0 = 0;
            if (g1) req1 = 0;
            n++;
        end
        check("t4_both_granted", int'(g0 && g1), 1);
        check("t4_first_port", order_q.size() > 0 ? int'(order_q[0]) : 9, 0);
        drain();
        check("t4_last_rdata", rdata, 8'h5A);

        // 6: STROBE_CYCLES=1 instance
        begin
            int gc = 0, dc = -1, oe_cnt = 0;
            bit got = 0;
            s_addr0 = 15'd9; s_req0 = 1;
            n = 0;
            while (!got && n < 20) begin @(negedge clk); got = s_gnt0; n++; end
            check("t6_grant", int'(got), 1);
            gc = cyc;
            @(posedge clk); #1 s_req0 = 0;
            n = 0;
            while (dc < 0 && n < 20) begin
                @(negedge clk);
                if (!s_oe) oe_cnt++;
                if (s_done0) dc = cyc;
                n++;
            end
            check("t6_oe_len", oe_cnt, 1);
            check("t6_done_lat", dc - gc, 3);
            check("t6_rdata", s_rdata, 8'hAA);
        end

        check("inv_oe_we_both", oe_we_both, 0);
        check("inv_a_change", a_change, 0);
        check("inv_gnt_overlap", gnt_overlap, 0);
        check("inv_wr_bus", wr_bus_err, 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
